// File: rtl/delay_line_if.sv
// Bus bundle for the programmable delay line: stimulus/config in, delayed data and status out.
interface delay_line_if #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned MAX_DELAY = 16
);
    localparam int unsigned CFG_W = $clog2(MAX_DELAY + 1);

    logic [WIDTH-1:0] sig_in;
    logic [CFG_W-1:0] delay_cfg;
    logic [WIDTH-1:0] sig_out;
    logic             primed;
    logic [CFG_W-1:0] active_delay;

    modport master (
        output sig_in, delay_cfg,
        input  sig_out, primed, active_delay
    );

    modport slave (
        input  sig_in, delay_cfg,
        output sig_out, primed, active_delay
    );
endinterface

// File: rtl/delay_line.sv
// Programmable delay line: ring buffer with a fill counter; any change of the
// clamped delay flushes the history so no pre-change data ever reaches sig_out.
module delay_line #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned MAX_DELAY = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    delay_line_if.slave  bus
);
    localparam int unsigned CFG_W = $clog2(MAX_DELAY + 1);
    localparam int unsigned PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [CFG_W-1:0] CFG_ONE  = CFG_W'(1);
    localparam logic [CFG_W-1:0] CFG_MAX  = CFG_W'(MAX_DELAY);
    localparam logic [CFG_W:0]   SPAN     = (CFG_W + 1)'(MAX_DELAY);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_DELAY - 1);

    logic [WIDTH-1:0] mem_q [MAX_DELAY];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
    logic [CFG_W-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CFG_W-1:0] d_eff, lag;
    logic [WIDTH-1:0] out_q, out_d;
    logic             primed_q, primed_d;
    logic             flush;
    logic [CFG_W:0]   rd_raw, rd_wrap;

    always_comb begin
        if (bus.delay_cfg == '0)
            d_eff = CFG_ONE;
        else if (bus.delay_cfg > CFG_MAX)
            d_eff = CFG_MAX;
        else
            d_eff = bus.delay_cfg;

        flush = (d_eff != active_q);
        lag   = active_q - CFG_ONE;

        // Sample captured lag edges ago sits lag slots behind the write pointer.
        rd_raw  = (CFG_W + 1)'(wr_ptr_q) + SPAN - {1'b0, lag};
        rd_wrap = (rd_raw >= SPAN) ? (rd_raw - SPAN) : rd_raw;
        rd_ptr  = PTR_W'(rd_wrap);

        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        out_d    = out_q;
        primed_d = primed_q;

        if (flush) begin
            active_d = d_eff;
            out_d    = '0;
            primed_d = 1'b0;
            cnt_d    = '0;
            wr_ptr_d = '0;
        end else begin
            if (active_q == CFG_ONE)
                out_d = bus.sig_in;
            else if (cnt_q >= lag)
                out_d = mem_q[rd_ptr];
            else
                out_d = '0;

            if (({1'b0, cnt_q} + (CFG_W + 1)'(1)) >= {1'b0, active_q})
                primed_d = 1'b1;

            cnt_d    = (cnt_q == CFG_MAX) ? cnt_q : cnt_q + CFG_ONE;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            active_q <= CFG_ONE;
            out_q    <= '0;
            primed_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_DELAY; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            out_q    <= out_d;
            primed_q <= primed_d;
            if (flush) begin
                for (int unsigned i = 0; i < MAX_DELAY; i++)
                    mem_q[i] <= '0;
            end else begin
                mem_q[wr_ptr_q] <= bus.sig_in;
            end
        end
    end

    assign bus.sig_out      = out_q;
    assign bus.primed       = primed_q;
    assign bus.active_delay = active_q;
endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (WIDTH=8, MAX_DELAY=16).
module tb_delay_line;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_DELAY = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    delay_line_if #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) bus ();

    delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input int din, input int cfg);
        rst_n         = r;
        bus.sig_in    = din[WIDTH-1:0];
        bus.delay_cfg = cfg[4:0];
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int o, input int p, input int ad);
        chk({tag, ".out"}, int'(bus.sig_out), o);
        chk({tag, ".primed"}, int'(bus.primed), p);
        chk({tag, ".delay"}, int'(bus.active_delay), ad);
    endtask

    initial begin
        bus.sig_in    = '0;
        bus.delay_cfg = '0;
        @(negedge clk);

        // Reset held 3 edges with sig_in high
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1, 1);
            expect3("reset", 0, 0, 1);
        end

        // D=1 single pulse
        step(1'b1, 0, 1); expect3("d1_e1", 0, 1, 1);
        step(1'b1, 1, 1); expect3("d1_e2", 1, 1, 1);
        step(1'b1, 0, 1); expect3("d1_e3", 0, 1, 1);

        // cfg=0 clamps to 1: no flush, plain register
        step(1'b1, 7, 0); expect3("cfg0_a", 7, 1, 1);
        step(1'b1, 9, 0); expect3("cfg0_b", 9, 1, 1);

        // D=5 counting sequence, change edge discards its input
        step(1'b1, 170, 5); expect3("d5_flush", 0, 0, 5);
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, k, 5);
            expect3("d5_seq", (k >= 5) ? k - 4 : 0, (k >= 5) ? 1 : 0, 5);
        end

        // D=4 stream, then switch to D=2 mid-stream
        step(1'b1, 19, 4); expect3("d4_flush", 0, 0, 4);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 19 + i, 4);
            expect3("d4_seq", (i >= 4) ? 16 + i : 0, (i >= 4) ? 1 : 0, 4);
        end
        step(1'b1, 30, 2); expect3("d2_flush", 0, 0, 2);
        step(1'b1, 31, 2); expect3("d2_c1", 0, 0, 2);
        step(1'b1, 32, 2); expect3("d2_c2", 31, 1, 2);
        step(1'b1, 33, 2); expect3("d2_c3", 32, 1, 2);
        step(1'b1, 34, 2); expect3("d2_c4", 33, 1, 2);

        // cfg=MAX+3 clamps to 16; run 45 captures to cross pointer wrap twice
        step(1'b1, 99, MAX_DELAY + 3); expect3("d16_flush", 0, 0, 16);
        for (int i = 1; i <= 45; i++) begin
            step(1'b1, 100 + i, MAX_DELAY + 3);
            expect3("d16_seq", (i >= 16) ? 85 + i : 0, (i >= 16) ? 1 : 0, 16);
        end

        // D=8 stream, reset after 20 cycles, then refill
        step(1'b1, 199, 8); expect3("d8_flush", 0, 0, 8);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 200 + i, 8);
            expect3("d8_seq", (i >= 8) ? 193 + i : 0, (i >= 8) ? 1 : 0, 8);
        end
        step(1'b0, 85, 8); expect3("mid_reset", 0, 0, 1);
        step(1'b1, 49, 8); expect3("post_rst_flush", 0, 0, 8);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 50 + i, 8);
            expect3("post_rst_seq", (i >= 8) ? 43 + i : 0, (i >= 8) ? 1 : 0, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/delay_line.md
Name: delay_line

Overview:
- Clocked, programmable digital delay line.
- Reproduces its input bus on the output a run-time-selected number of clock cycles later.
- Used wherever a signal must be realigned with a slower path, or a stimulus edge must be shifted in time (e.g. pulse `signal` -> `delayed`).
- Implemented as a ring buffer with write/read pointers, a fill counter and config-change detection.

Parameters:
- WIDTH, 1, bit width of the delayed bus.
- MAX_DELAY, 16, largest supported delay in clock cycles; must be >= 1.
- CFG_W, $clog2(MAX_DELAY+1), width of delay_cfg; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- sig_in  input  WIDTH  signal to be delayed, sampled every enabled edge.
- delay_cfg  input  CFG_W  requested delay in cycles.
- sig_out  output  WIDTH  delayed copy of sig_in; registered.
- primed  output  1  high once the line holds D genuine samples since the last reset/flush.
- active_delay  output  CFG_W  effective delay D currently in use; registered.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - sig_out=0, primed=0, active_delay=1.
  - All stored history treated as 0; pointers/counters cleared; sig_in ignored at that edge.
  - Reset asserted mid-operation has an identical effect.
- Effective delay: D = clamp(delay_cfg, 1, MAX_DELAY). delay_cfg=0 acts as 1; values > MAX_DELAY act as MAX_DELAY.
- Normal edge (rst_n=1, D == active_delay):
  - sig_in is captured.
  - sig_out after edge n = sig_in captured at edge n-D+1. D=1 is a plain register; D=k is a k-stage shift.
  - Captures before the last reset/flush read as 0.
- Flush edge (rst_n=1, D != active_delay):
  - active_delay<=D, sig_out<=0, primed<=0, history cleared.
  - sig_in at this edge is discarded; capturing resumes next edge.
- primed:
  - Counts captures since the last reset/flush; goes high on the edge of the D-th capture.
  - Stays high until the next reset/flush.
  - While primed=0, sig_out is 0 or a genuine delayed sample; never stale pre-flush data.
- Storage: MAX_DELAY-entry ring buffer (or equivalent). Pointer wrap at MAX_DELAY-1 -> 0 must be seamless, with no glitch or extra cycle at wrap.
- Precedence: reset > flush > normal capture.
- Fully synchronous: no combinational path sig_in -> sig_out, and no latches.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with sig_in=1 -> sig_out=0, primed=0, active_delay=1. Release -> first capture is at the next edge.
- Single pulse, delay_cfg=1, sig_in 0,1,0 on consecutive edges -> sig_out is 1 after the 2nd edge only. primed=1 after the 1st edge.
- delay_cfg=5, WIDTH=8, counting sequence 1,2,3,... -> sig_out after the edge capturing value k equals k-4. primed rises on the 5th capture; outputs before that are 0.
- Clamping: delay_cfg=0 behaves as D=1; delay_cfg=MAX_DELAY+3 (in range of CFG_W) -> active_delay=16, with a 16-cycle delay verified over more than 40 cycles to cover pointer wrap.
- Config change mid-stream, D 4->2 with a continuous stream -> at the change edge sig_out=0 and primed=0. The next 2 captures refill, then outputs are correct at D=2 with no old data emitted.
- Reset mid-stream at D=8 after 20 cycles -> outputs clear at that edge. After release, the first 7 outputs are 0 and primed rises on the 8th capture.
